// File: rtl/eth_phy_init_if.sv
// rtl/eth_phy_init_if.sv - PHY register request port (request/ack handshake)
interface eth_phy_init_if;
    logic        vld;
    logic [4:0]  addr;
    logic        write;
    logic [15:0] wval;
    logic [15:0] rval;
    logic        ack;

    modport master (
        output vld, addr, write, wval,
        input  rval, ack
    );

    modport slave (
        input  vld, addr, write, wval,
        output rval, ack
    );
endinterface

// File: rtl/eth_phy_init.sv
// rtl/eth_phy_init.sv - PHY bring-up sequencer and owner of the SMI register port
module eth_phy_init #(
    parameter int          POR_CYCLES = 1000000,
    parameter int          POLL_GAP   = 50000,
    parameter int          POLL_MAX   = 16,
    parameter int          MAX_RETRY  = 3,
    parameter logic [15:0] ADV_VAL    = 16'h01E1
) (
    input  logic           clk_mac,
    input  logic           rst_n,
    input  logic           reinit,
    eth_phy_init_if.slave  usr,
    eth_phy_init_if.master smi,
    output logic           init_done,
    output logic           init_fail,
    output logic           busy
);

    localparam int POR_W  = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PCNT_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam int RTRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_MAX - 1);
    localparam logic [RTRY_W-1:0] RTRY_SAT  = RTRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_POR,
        S_RST_WR,
        S_POLL_WAIT,
        S_POLL_RD,
        S_ADV_WR,
        S_AN_WR,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state_q, state_nxt;

    logic [POR_W-1:0]  por_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [PCNT_W-1:0] poll_cnt;
    logic [RTRY_W-1:0] retry_cnt;

    logic        vld_q;
    logic [4:0]  addr_q;
    logic        write_q;
    logic [15:0] wval_q;
    logic        usr_owner_q;
    logic        usr_ack_q;
    logic [15:0] usr_rval_q;
    logic        reinit_pend_q;
    logic        done_q;
    logic        fail_q;
    logic        busy_q;

    logic        txn_done;
    logic        reinit_req;
    logic        go_reinit;
    logic        req_en;
    logic        req_fire;
    logic [4:0]  req_addr;
    logic        req_write;
    logic [15:0] req_wval;
    logic        req_usr;
    logic        attempt_fail;
    logic        retry_last;

    // A request completes when its ack is sampled; a reinit may only act once nothing is in flight.
    assign txn_done   = vld_q && smi.ack;
    assign reinit_req = reinit || reinit_pend_q;
    assign go_reinit  = reinit_req && (!vld_q || smi.ack);
    assign retry_last = (int'(retry_cnt) + 1) >= MAX_RETRY;

    assign smi.vld   = vld_q;
    assign smi.addr  = addr_q;
    assign smi.write = write_q;
    assign smi.wval  = wval_q;
    assign usr.ack   = usr_ack_q;
    assign usr.rval  = usr_rval_q;
    assign init_done = done_q;
    assign init_fail = fail_q;
    assign busy      = busy_q;

    // State register.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_POR;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and the request each state wants on the SMI port.
    always_comb begin
        state_nxt    = state_q;
        req_en       = 1'b0;
        req_addr     = 5'd0;
        req_write    = 1'b0;
        req_wval     = 16'h0000;
        req_usr      = 1'b0;
        attempt_fail = 1'b0;
        case (state_q)
            S_POR: begin
                if (por_cnt == POR_LAST) state_nxt = S_RST_WR;
            end
            S_RST_WR: begin
                req_en    = 1'b1;
                req_write = 1'b1;
                req_wval  = 16'h8000;
                if (txn_done) state_nxt = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (gap_cnt == GAP_LAST) state_nxt = S_POLL_RD;
            end
            S_POLL_RD: begin
                req_en = 1'b1;
                if (txn_done) begin
                    if (!smi.rval[15]) begin
                        state_nxt = S_ADV_WR;
                    end else if (poll_cnt == POLL_LAST) begin
                        attempt_fail = 1'b1;
                        state_nxt    = retry_last ? S_FAIL : S_RST_WR;
                    end else begin
                        state_nxt = S_POLL_WAIT;
                    end
                end
            end
            S_ADV_WR: begin
                req_en    = 1'b1;
                req_addr  = 5'd4;
                req_write = 1'b1;
                req_wval  = ADV_VAL;
                if (txn_done) state_nxt = S_AN_WR;
            end
            S_AN_WR: begin
                req_en    = 1'b1;
                req_write = 1'b1;
                req_wval  = 16'h1200;
                if (txn_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                // usr_ack_q high means the user is dropping the request this cycle.
                req_en    = usr.vld && !usr_ack_q;
                req_addr  = usr.addr;
                req_write = usr.write;
                req_wval  = usr.wval;
                req_usr   = 1'b1;
            end
            S_FAIL: begin
            end
            default: state_nxt = S_POR;
        endcase
        if (go_reinit) begin
            state_nxt    = S_RST_WR;
            attempt_fail = 1'b0;
        end
        req_fire = req_en && !vld_q && !reinit_req;
    end

    // Sequencing counters; all saturate at their terminal value.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            por_cnt   <= '0;
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            if (state_q == S_POR && por_cnt != POR_LAST) por_cnt <= por_cnt + 1'b1;

            if (state_q != S_POLL_WAIT) gap_cnt <= '0;
            else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;

            if (state_q == S_RST_WR) poll_cnt <= '0;
            else if (state_q == S_POLL_RD && txn_done && smi.rval[15] && poll_cnt != POLL_LAST)
                poll_cnt <= poll_cnt + 1'b1;

            if (go_reinit) retry_cnt <= '0;
            else if (attempt_fail && retry_cnt != RTRY_SAT) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // SMI request register: raised from idle, held until ack, dropped on the ack edge.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 1'b0;
            addr_q      <= 5'd0;
            write_q     <= 1'b0;
            wval_q      <= 16'h0000;
            usr_owner_q <= 1'b0;
        end else if (txn_done) begin
            vld_q       <= 1'b0;
            usr_owner_q <= 1'b0;
        end else if (req_fire) begin
            vld_q       <= 1'b1;
            addr_q      <= req_addr;
            write_q     <= req_write;
            wval_q      <= req_wval;
            usr_owner_q <= req_usr;
        end
    end

    // User completion, deferred reinit and status flags.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            usr_ack_q     <= 1'b0;
            usr_rval_q    <= 16'h0000;
            reinit_pend_q <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            usr_ack_q <= txn_done && usr_owner_q;
            if (txn_done && usr_owner_q) usr_rval_q <= smi.rval;

            if (go_reinit) reinit_pend_q <= 1'b0;
            else if (reinit) reinit_pend_q <= 1'b1;

            done_q <= (state_nxt == S_DONE);
            fail_q <= (state_nxt == S_FAIL);
            busy_q <= (state_nxt != S_DONE) && (state_nxt != S_FAIL);
        end
    end

endmodule

// File: tb/tb_eth_phy_init.sv
// tb/tb_eth_phy_init.sv - self-checking bench for eth_phy_init
module tb_eth_phy_init;

    localparam int POR_CYCLES = 10;
    localparam int POLL_GAP   = 4;
    localparam int POLL_MAX   = 3;
    localparam int MAX_RETRY  = 2;

    typedef struct {
        logic [4:0]  addr;
        logic        write;
        logic [15:0] wval;
        int          t_start;
        int          t_end;
    } req_t;

    logic clk_mac = 1'b0;
    logic rst_n   = 1'b0;
    logic reinit  = 1'b0;
    logic init_done, init_fail, busy;

    eth_phy_init_if usr_if();
    eth_phy_init_if smi_if();

    eth_phy_init #(
        .POR_CYCLES(POR_CYCLES),
        .POLL_GAP  (POLL_GAP),
        .POLL_MAX  (POLL_MAX),
        .MAX_RETRY (MAX_RETRY),
        .ADV_VAL   (16'h01E1)
    ) dut (
        .clk_mac  (clk_mac),
        .rst_n    (rst_n),
        .reinit   (reinit),
        .usr      (usr_if),
        .smi      (smi_if),
        .init_done(init_done),
        .init_fail(init_fail),
        .busy     (busy)
    );

    always #5 clk_mac = ~clk_mac;

    int cyc = 0;
    always @(posedge clk_mac) cyc <= cyc + 1;

    req_t        exp_q[$];
    req_t        obs_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] dflt_rval;
    int          viol;
    int          last_ack_cyc;
    int          total = 0;
    int          bad   = 0;

    // SMI model: acks 5 cycles after reg_vld, logs each completed request.
    initial begin : smi_model
        req_t cur;
        int   wcnt;
        wcnt = 0;
        smi_if.ack  = 1'b0;
        smi_if.rval = 16'h0000;
        forever begin
            @(posedge clk_mac);
            #1;
            if (!rst_n) begin
                smi_if.ack = 1'b0;
                wcnt = 0;
            end else if (smi_if.ack) begin
                smi_if.ack   = 1'b0;
                last_ack_cyc = cyc;
                if (smi_if.vld !== 1'b0) viol++;
            end else if (smi_if.vld === 1'b1) begin
                if (wcnt == 0) begin
                    cur.addr    = smi_if.addr;
                    cur.write   = smi_if.write;
                    cur.wval    = smi_if.wval;
                    cur.t_start = cyc;
                end else if (smi_if.addr !== cur.addr || smi_if.write !== cur.write ||
                             smi_if.wval !== cur.wval) begin
                    viol++;
                end
                wcnt++;
                if (wcnt == 5) begin
                    wcnt = 0;
                    smi_if.ack = 1'b1;
                    if (cur.write) smi_if.rval = 16'h0000;
                    else if (rsp_q.size() > 0) smi_if.rval = rsp_q.pop_front();
                    else smi_if.rval = dflt_rval;
                    cur.t_end = cyc + 1;
                    obs_q.push_back(cur);
                end
            end
        end
    end

    task automatic push_exp(input logic [4:0] a, input logic w, input logic [15:0] v);
        req_t r;
        r.addr = a; r.write = w; r.wval = v; r.t_start = 0; r.t_end = 0;
        exp_q.push_back(r);
    endtask

    task automatic push_init_seq();
        push_exp(5'd0, 1'b1, 16'h8000);
        push_exp(5'd0, 1'b0, 16'h0000);
        push_exp(5'd4, 1'b1, 16'h01E1);
        push_exp(5'd0, 1'b1, 16'h1200);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reinit = 1'b0;
        usr_if.vld = 1'b0; usr_if.addr = 5'd0; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        exp_q.delete(); obs_q.delete(); rsp_q.delete();
        dflt_rval = 16'h0000;
        viol = 0;
        repeat (2) @(negedge clk_mac);
        rst_n = 1'b1;
    endtask

    // sel: 0 init_done, 1 init_fail, 2 usr ack, 3 reg_vld
    task automatic wait_for(input int sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_mac);
            if ((sel == 0 && init_done === 1'b1) || (sel == 1 && init_fail === 1'b1) ||
                (sel == 2 && usr_if.ack === 1'b1) || (sel == 3 && smi_if.vld === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int k;
        bit ok;
        rst_n = 1'b0;
        usr_if.vld = 1'b0; usr_if.addr = 5'd0; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        exp_q.delete(); obs_q.delete(); rsp_q.delete();
        @(negedge clk_mac);
        total++;
        if ({init_done, init_fail, busy, smi_if.vld, smi_if.write, usr_if.ack} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {init_done, init_fail, busy, smi_if.vld, smi_if.write, usr_if.ack});
        end
        total++;
        if (smi_if.addr !== 5'd0 || smi_if.wval !== 16'h0 || usr_if.rval !== 16'h0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wval=%h rval=%h want 0",
                     smi_if.addr, smi_if.wval, usr_if.rval);
        end
        k = cyc;
        rst_n = 1'b1;
        @(negedge clk_mac);
        total++;
        if (busy !== 1'b1 || init_done !== 1'b0 || smi_if.vld !== 1'b0) begin
            bad++;
            $display("FAIL por_state: got busy=%b done=%b vld=%b want 1 0 0", busy, init_done, smi_if.vld);
        end
        wait_for(3, 100, ok);
        total++;
        if (!ok || (cyc - k) != POR_CYCLES + 1) begin
            bad++;
            $display("FAIL por_length: got %0d cycles (seen=%b) want %0d", cyc - k, ok, POR_CYCLES + 1);
        end
    endtask

    task automatic test_nominal();
        bit ok;
        req_t e, o;
        do_reset();
        push_init_seq();
        wait_for(0, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nominal_done: got timeout want init_done"); end
        total++;
        if (cyc != last_ack_cyc) begin
            bad++;
            $display("FAIL nominal_done_timing: got edge %0d want %0d", cyc, last_ack_cyc);
        end
        total++;
        if (busy !== 1'b0 || init_fail !== 1'b0) begin
            bad++;
            $display("FAIL nominal_flags: got busy=%b fail=%b want 0 0", busy, init_fail);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL nominal_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL nominal_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL nominal_handshake: got %0d violations want 0", viol); end
    endtask

    task automatic test_slow_reset();
        bit ok;
        bit have_prev;
        req_t e, o, prev;
        do_reset();
        rsp_q.push_back(16'h8000); rsp_q.push_back(16'h8000); rsp_q.push_back(16'h3100);
        push_exp(5'd0, 1'b1, 16'h8000);
        push_exp(5'd0, 1'b0, 16'h0000);
        push_exp(5'd0, 1'b0, 16'h0000);
        push_exp(5'd0, 1'b0, 16'h0000);
        push_exp(5'd4, 1'b1, 16'h01E1);
        push_exp(5'd0, 1'b1, 16'h1200);
        wait_for(0, 600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL slow_done: got timeout want init_done"); end
        have_prev = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL slow_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL slow_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
                if (have_prev && prev.write === 1'b0 && o.write === 1'b0) begin
                    total++;
                    if (o.t_start - prev.t_end < POLL_GAP) begin
                        bad++;
                        $display("FAIL slow_poll_gap: got %0d idle want >=%0d", o.t_start - prev.t_end, POLL_GAP);
                    end
                end
                prev = o;
                have_prev = 1'b1;
            end
        end
    endtask

    task automatic test_fail();
        bit ok;
        req_t e, o;
        do_reset();
        dflt_rval = 16'h8000;
        for (int a = 0; a < MAX_RETRY; a++) begin
            push_exp(5'd0, 1'b1, 16'h8000);
            for (int p = 0; p < POLL_MAX; p++) push_exp(5'd0, 1'b0, 16'h0000);
        end
        wait_for(1, 800, ok);
        total++;
        if (!ok || busy !== 1'b0 || init_done !== 1'b0) begin
            bad++;
            $display("FAIL fail_state: got fail=%b busy=%b done=%b want 1 0 0", init_fail, busy, init_done);
        end
        repeat (40) @(negedge clk_mac);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL fail_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL fail_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
        total++;
        if (obs_q.size() != 0 || smi_if.vld !== 1'b0 || init_fail !== 1'b1) begin
            bad++;
            $display("FAIL fail_quiet: got extra=%0d vld=%b fail=%b want 0 0 1", obs_q.size(), smi_if.vld, init_fail);
        end
        dflt_rval = 16'h0000;
        push_init_seq();
        reinit = 1'b1;
        @(negedge clk_mac);
        reinit = 1'b0;
        total++;
        if (init_fail !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fail_reinit: got fail=%b busy=%b want 0 1", init_fail, busy);
        end
        wait_for(0, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fail_reinit_done: got timeout want init_done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL fail_reinit_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL fail_reinit_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
    endtask

    task automatic test_passthrough();
        bit ok;
        req_t e, o;
        do_reset();
        wait_for(0, 400, ok);
        obs_q.delete();
        rsp_q.push_back(16'h786D);
        push_exp(5'd1, 1'b0, 16'h0000);
        push_exp(5'd9, 1'b1, 16'h1234);
        usr_if.vld = 1'b1; usr_if.addr = 5'd1; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        wait_for(2, 100, ok);
        total++;
        if (!ok || usr_if.rval !== 16'h786D) begin
            bad++; $display("FAIL pt_read_data: got %h (ack=%b) want 786d", usr_if.rval, ok);
        end
        total++;
        if (cyc != last_ack_cyc) begin
            bad++; $display("FAIL pt_ack_latency: got edge %0d want %0d", cyc, last_ack_cyc);
        end
        usr_if.vld = 1'b0;
        @(negedge clk_mac);
        total++;
        if (usr_if.ack !== 1'b0) begin bad++; $display("FAIL pt_ack_pulse: got %b want 0", usr_if.ack); end
        usr_if.vld = 1'b1; usr_if.addr = 5'd9; usr_if.write = 1'b1; usr_if.wval = 16'h1234;
        wait_for(2, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL pt_write_ack: got timeout want usr_ack"); end
        usr_if.vld = 1'b0;
        repeat (15) @(negedge clk_mac);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL pt_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL pt_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
        total++;
        if (obs_q.size() != 0 || viol != 0) begin
            bad++; $display("FAIL pt_extra: got extra=%0d viol=%0d want 0 0", obs_q.size(), viol);
        end
    endtask

    task automatic test_early_user();
        bit ok;
        req_t e, o;
        do_reset();
        usr_if.vld = 1'b1; usr_if.addr = 5'd5; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        rsp_q.push_back(16'h0000); rsp_q.push_back(16'hAB12);
        push_init_seq();
        push_exp(5'd5, 1'b0, 16'h0000);
        wait_for(2, 500, ok);
        total++;
        if (!ok || usr_if.rval !== 16'hAB12 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL early_served: got ack=%b rval=%h done=%b want 1 ab12 1", ok, usr_if.rval, init_done);
        end
        usr_if.vld = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL early_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL early_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
    endtask

    task automatic test_reinit();
        bit ok;
        req_t e, o;
        do_reset();
        wait_for(0, 400, ok);
        obs_q.delete();
        rsp_q.push_back(16'h5555);
        push_exp(5'd2, 1'b0, 16'h0000);
        push_init_seq();
        usr_if.vld = 1'b1; usr_if.addr = 5'd2; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        wait_for(3, 20, ok);
        @(negedge clk_mac);
        reinit = 1'b1;
        @(negedge clk_mac);
        reinit = 1'b0;
        wait_for(2, 20, ok);
        total++;
        if (!ok || usr_if.rval !== 16'h5555) begin
            bad++; $display("FAIL reinit_usr_ack: got ack=%b rval=%h want 1 5555", ok, usr_if.rval);
        end
        total++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL reinit_flags: got done=%b busy=%b want 0 1", init_done, busy);
        end
        usr_if.vld = 1'b0;
        wait_for(0, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reinit_done: got timeout want init_done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL reinit_req: got none want %h/%b/%h", e.addr, e.write, e.wval);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.write !== e.write || o.wval !== e.wval) begin
                    bad++;
                    $display("FAIL reinit_req: got %h/%b/%h want %h/%b/%h",
                             o.addr, o.write, o.wval, e.addr, e.write, e.wval);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        wait_for(3, 50, ok);
        repeat (2) @(negedge clk_mac);
        #2;
        total++;
        if (!ok || smi_if.vld !== 1'b1) begin
            bad++; $display("FAIL arst_setup: got vld=%b want 1", smi_if.vld);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({smi_if.vld, smi_if.write, busy, init_done, init_fail, usr_if.ack} !== 6'b0 ||
            smi_if.addr !== 5'd0 || smi_if.wval !== 16'h0) begin
            bad++;
            $display("FAIL arst_outputs: got vld=%b wr=%b busy=%b addr=%h wval=%h want all 0",
                     smi_if.vld, smi_if.write, busy, smi_if.addr, smi_if.wval);
        end
        @(negedge clk_mac);
        rst_n = 1'b1;
    endtask

    initial begin
        usr_if.vld = 1'b0; usr_if.addr = 5'd0; usr_if.write = 1'b0; usr_if.wval = 16'h0000;
        dflt_rval = 16'h0000;
        viol = 0;
        last_ack_cyc = 0;
        test_reset();
        test_nominal();
        test_slow_reset();
        test_fail();
        test_passthrough();
        test_early_user();
        test_reinit();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_phy_init.md
Name: eth_phy_init

Overview:
- PHY bring-up sequencer and register-port owner for the Ethernet MAC subsystem.
- Sits in front of the SMI configuration block's register request port (reg_vld/reg_addr/reg_write/reg_wval/reg_rval/reg_ack).
- After power-up it soft-resets the PHY, polls for reset completion, programs auto-negotiation advertisement and restarts auto-negotiation.
- It then hands the register port to a single user client by pass-through, and re-runs the sequence on request.

Parameters:
- POR_CYCLES, 1000000, clk_mac cycles waited after reset release before the first SMI access (20 ms at 50 MHz).
- POLL_GAP, 50000, idle cycles between successive reset-status polls.
- POLL_MAX, 16, reset-status polls allowed per attempt before the attempt fails.
- MAX_RETRY, 3, failed attempts tolerated before init_fail is set.
- ADV_VAL, 16'h01E1, value written to PHY register 4 (advertise 10/100, half/full duplex, 802.3).

Ports:
- clk_mac  in  1  MAC clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reinit  in  1  single-cycle pulse; restart the bring-up sequence.
- usr_vld  in  1  user request; held until usr_ack.
- usr_addr  in  5  user PHY register address.
- usr_write  in  1  1 = write, 0 = read.
- usr_wval  in  16  user write data.
- usr_rval  out  16  user read data; valid with usr_ack.
- usr_ack  out  1  single-cycle completion pulse to the user.
- reg_vld  out  1  request to the SMI configuration block.
- reg_addr  out  5  request address.
- reg_write  out  1  request type.
- reg_wval  out  16  request write data.
- reg_rval  in  16  read data; valid with reg_ack.
- reg_ack  in  1  single-cycle completion from the SMI configuration block.
- init_done  out  1  sequence complete; user port live.
- init_fail  out  1  sticky; MAX_RETRY attempts failed.
- busy  out  1  high in every state except DONE and FAIL.

Behaviour:
- Reset values: all outputs 0; state POR; counters 0.
- Master rule: reg_vld/addr/write/wval are registered and held stable until reg_ack. reg_vld must be 0 in the cycle after reg_ack is sampled; it is never re-raised in that cycle.
- One request is outstanding at a time.

States:
- POR: count to POR_CYCLES-1, then go to RST_WR.
- RST_WR: write reg 0 = 16'h8000. On reg_ack go to POLL_WAIT with poll count 0.
- POLL_WAIT: count POLL_GAP cycles, then go to POLL_RD.
- POLL_RD: read reg 0. On reg_ack:
  - reg_rval[15]=0: go to ADV_WR.
  - else increment poll count; if it reaches POLL_MAX, the attempt fails; otherwise go to POLL_WAIT.
- ADV_WR: write reg 4 = ADV_VAL. On reg_ack go to AN_WR.
- AN_WR: write reg 0 = 16'h1200 (AN enable + restart). On reg_ack go to DONE.
- DONE: init_done=1. Pass-through: reg_* = usr_*. usr_rval and usr_ack are registered copies of reg_rval/reg_ack, so the user sees 1 cycle of added latency.
- FAIL: init_fail=1, busy=0. Only reinit or rst_n leave this state.

Attempt failure:
- Increment the retry count. If retry count ≥ MAX_RETRY, go to FAIL; otherwise go to RST_WR.
- The poll counter clears on every RST_WR entry.

User port outside DONE:
- usr_vld is ignored; usr_ack stays 0. The request stays pending and is served once DONE is reached.

reinit handling:
- Clears init_done, retry count and init_fail. Next state is RST_WR; POR is not repeated.
- If a request is outstanding (user or internal), the block waits for its reg_ack first. A user request completed this way still gets its usr_ack.
- reinit during POR or POLL_WAIT takes effect immediately.
- reinit coincident with reg_ack: the ack completes the transaction, then the block goes to RST_WR.

Other rules:
- Asynchronous rst_n mid-transaction aborts to POR with reg_vld=0. The downstream block is reset by the same rst_n.
- Counters saturate and do not wrap. POR/POLL counters are sized by $clog2 of their parameter.

Test Plan:
- Bench parameters: POR_CYCLES=10, POLL_GAP=4, POLL_MAX=3, MAX_RETRY=2. The SMI model acks 5 cycles after reg_vld.
- Nominal: model returns reg0=16'h0000 on the first poll → request order: W0=8000, R0, W4=01E1, W0=1200. init_done rises 1 cycle after the last ack; busy falls together with it.
- Slow reset: first two polls return 16'h8000, third returns 16'h3100 → exactly 3 R0 requests, each separated by ≥4 idle cycles; then W4 follows.
- Failure: polls always return 16'h8000 → 2 attempts of W0=8000 plus 3 R0 each, then init_fail=1, busy=0, and no further reg_vld.
- Pass-through: in DONE, user read of reg 1 with the model returning 16'h786D → usr_rval=786D with usr_ack 1 cycle after reg_ack. reg_vld is low in the cycle after reg_ack.
- Early user request: usr_vld raised during POR → no reg_vld with addr=usr_addr before init_done. The request is served first after DONE.
- reinit mid user read: pulse while a user request is outstanding → usr_ack still delivered; next request is W0=8000 and init_done=0. Async rst_n asserted mid-write → all outputs 0 in the same cycle.
